// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate data cache between
// the MEM stage and the SRAM controller. Read hits complete with no freeze.
module cache_controller #(
  parameter int SETS      = 64,
  parameter int BASE_ADDR = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        sram_read_enable,
  output logic        sram_write_enable,
  output logic [31:0] sram_address,
  output logic [31:0] sram_write_data,
  input  logic [31:0] sram_read_data,
  input  logic        sram_ready
);

  localparam int IDX_W   = $clog2(SETS);
  localparam int TAG_W   = 11;
  localparam int TAG_LSB = IDX_W + 2;

  typedef enum logic [1:0] {IDLE, READ_MISS, WRITE} state_t;

  state_t            r_state, w_next;
  logic [SETS-1:0]   r_valid0, r_valid1, r_lru;
  logic [TAG_W-1:0]  r_tag0  [SETS];
  logic [TAG_W-1:0]  r_tag1  [SETS];
  logic [31:0]       r_data0 [SETS];
  logic [31:0]       r_data1 [SETS];

  logic [31:0]       w_ea;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit0, w_hit1, w_hit, w_victim;
  logic              w_wr_hit, w_rd_hit, w_fill, w_unused_ea;

  assign w_ea        = address - 32'(BASE_ADDR);
  assign w_idx       = w_ea[TAG_LSB-1:2];
  assign w_tag       = w_ea[TAG_LSB+TAG_W-1:TAG_LSB];
  assign w_unused_ea = ^{w_ea[31:TAG_LSB+TAG_W], w_ea[1:0]};

  assign w_hit0   = r_valid0[w_idx] && (r_tag0[w_idx] == w_tag);
  assign w_hit1   = r_valid1[w_idx] && (r_tag1[w_idx] == w_tag);
  assign w_hit    = w_hit0 || w_hit1;
  // Invalid ways are filled before anything is evicted; way0 first.
  assign w_victim = !r_valid0[w_idx] ? 1'b0 : (!r_valid1[w_idx] ? 1'b1 : r_lru[w_idx]);

  assign w_wr_hit = (r_state == IDLE) && write_enable && w_hit;
  assign w_rd_hit = (r_state == IDLE) && !write_enable && read_enable && w_hit;
  assign w_fill   = (r_state == READ_MISS) && sram_ready;

  assign sram_address    = address;
  assign sram_write_data = write_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_valid0 <= '0;
      r_valid1 <= '0;
      r_lru    <= '0;
    end else begin
      r_state <= w_next;
      if (w_wr_hit || w_rd_hit) r_lru[w_idx] <= w_hit0;
      if (w_fill) begin
        if (w_victim) r_valid1[w_idx] <= 1'b1;
        else          r_valid0[w_idx] <= 1'b1;
        r_lru[w_idx] <= ~w_victim;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_hit) begin
      if (w_hit0) r_data0[w_idx] <= write_data;
      else        r_data1[w_idx] <= write_data;
    end
    if (w_fill) begin
      if (w_victim) begin
        r_tag1[w_idx]  <= w_tag;
        r_data1[w_idx] <= sram_read_data;
      end else begin
        r_tag0[w_idx]  <= w_tag;
        r_data0[w_idx] <= sram_read_data;
      end
    end
  end

  // Outputs are forced to their idle values while reset is held so the SRAM
  // side is released at once even if a MEM request is still asserted.
  always_comb begin
    w_next            = r_state;
    ready             = 1'b1;
    read_data         = 32'd0;
    sram_read_enable  = 1'b0;
    sram_write_enable = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (write_enable) begin
            w_next = WRITE;
            ready  = 1'b0;
          end else if (read_enable) begin
            if (w_hit) begin
              read_data = w_hit0 ? r_data0[w_idx] : r_data1[w_idx];
            end else begin
              w_next = READ_MISS;
              ready  = 1'b0;
            end
          end
        end
        READ_MISS: begin
          sram_read_enable = 1'b1;
          ready            = sram_ready;
          if (sram_ready) begin
            read_data = sram_read_data;
            w_next    = IDLE;
          end
        end
        WRITE: begin
          sram_write_enable = 1'b1;
          ready             = sram_ready;
          if (sram_ready) w_next = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

endmodule

// File: doc/cache_controller.md
# cache_controller

Two-way set-associative, write-through, no-write-allocate data cache between the MEM stage and the SRAM controller. Read hits complete in the issuing cycle with no pipeline freeze. Misses and all writes are forwarded to the SRAM controller over its enable/ready handshake, and `ready` is held low until the SRAM side completes.

## Interface
- `SETS`, default 64: number of sets (index = 6 bits).
- `BASE_ADDR`, default 1024: byte offset subtracted from `address` before index/tag extraction.
- `clk` input, 1 bit: clock; all state updates on posedge.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `read_enable` input, 1 bit: MEM-stage load request.
- `write_enable` input, 1 bit: MEM-stage store request.
- `address` input, 32 bits: byte address, word-aligned (bits [1:0] ignored).
- `write_data` input, 32 bits: store data.
- `read_data` output, 32 bits: load data, valid while `ready`=1 on a read.
- `ready` output, 1 bit: 0 freezes the pipeline.
- `sram_read_enable` output, 1 bit: read request to the SRAM controller.
- `sram_write_enable` output, 1 bit: write request to the SRAM controller.
- `sram_address` output, 32 bits: equals `address`, passed through unmodified.
- `sram_write_data` output, 32 bits: equals `write_data`.
- `sram_read_data` input, 32 bits: SRAM controller read result.
- `sram_ready` input, 1 bit: SRAM controller ready.

## Operation
- Effective address `ea = address - BASE_ADDR`, 32-bit wrap-around.
  - `index = ea[7:2]`, `tag = ea[18:8]` (11 bits).
- Storage per set:
  - way0 and way1, each holding `valid`, `tag[10:0]` and `data[31:0]`.
  - One `lru` bit naming the least-recently-used way.
- Hit on way w: `valid[w]` && `tag[w]==tag`. Both ways never hold the same tag.
- States: IDLE, READ_MISS, WRITE.
- IDLE, with `write_enable`=1 (write has priority over read when both are asserted):
  - Go to WRITE.
  - On a hit, update the hit way's data with `write_data` at the same edge and set `lru` to the other way.
  - On a miss, cache contents are unchanged.
- IDLE, with `read_enable`=1 and a hit:
  - `read_data` = hit way's data and `ready`=1; the state stays IDLE.
  - At the edge, `lru` is set to the way that did not hit.
- IDLE, with `read_enable`=1 and a miss: go to READ_MISS.
- IDLE, with neither request asserted: `ready`=1 and `read_data`=0.
- READ_MISS:
  - `sram_read_enable`=1 and `ready`=0.
  - On the first posedge with `sram_ready`=1, the completion cycle, fill the victim way:
    - Victim is way0 if way0 is invalid, otherwise way1 if way1 is invalid, otherwise the way named by `lru`.
    - Fill `valid`=1, `tag` and `data=sram_read_data`; set `lru` to the non-victim way; return to IDLE.
- WRITE:
  - `sram_write_enable`=1 and `ready`=0.
  - On the first posedge with `sram_ready`=1, return to IDLE.
- Completion cycle (both states): `ready`=1 combinationally while `sram_ready`=1. For READ_MISS, `read_data`=`sram_read_data` in that cycle.
- Reset:
  - All `valid` and `lru` bits are cleared and the state goes to IDLE immediately.
  - Both `sram_*_enable` drop to 0 asynchronously, including when reset lands mid-miss or mid-write.

## Timing
- Reset values: `ready`=1, `read_data`=0, `sram_read_enable`=0, `sram_write_enable`=0, state IDLE.
- `ready`, `read_data` and `sram_*_enable` are combinational from state, inputs and arrays. Everything else is registered.
- Read hit: 0 stall cycles.
- Read miss or write: stall starts in the request cycle. It ends in the cycle `sram_ready` is sampled 1 while in READ_MISS or WRITE.
- The `sram_ready`=1 already present in the request cycle itself is ignored; the cache is still in IDLE then.
- `sram_*_enable` deasserts in the cycle after completion, because the state is IDLE again. This prevents the SRAM controller from restarting.
- With the team's SRAM controller, a miss or write costs 8 stall cycles. The cache must not depend on that number.
- Inputs from the MEM stage are held stable while `ready`=0.

## Test plan
- Cold read:
  - Stimulus: after reset, read `address`=0x400, with the SRAM model returning 0xDEADBEEF after 7 cycles.
  - Required: `ready` low for the whole stall, `read_data`=0xDEADBEEF in the completion cycle, a single SRAM read issued, way0 of set 0 filled.
  - Then re-read 0x400: hit, `ready` stays 1 with no stall, `read_data`=0xDEADBEEF, no SRAM request.
- Conflict and LRU:
  - Stimulus: read miss 0x400 (tag 0), then 0x500 (tag 1, set 0), then a hit on 0x400, then 0x600 (tag 2).
  - Required: 0x600 evicts 0x500 (way1). A read of 0x400 still hits; a read of 0x500 misses.
- Write hit:
  - Stimulus: 0x400 cached; write 0x12345678 to 0x400.
  - Required: SRAM write issued with `sram_address`=0x400 and `sram_write_data`=0x12345678; `ready` low until `sram_ready`.
  - Then read 0x400: hits and returns 0x12345678 with no stall.
- Write miss:
  - Stimulus: write to 0x700 (uncached), then read 0x700.
  - Required: the write goes through to SRAM; the read misses, proving no allocate on write.
- Simultaneous requests and reset:
  - Stimulus: assert `read_enable` and `write_enable` together.
  - Required: the cycle is handled as a write, with only `sram_write_enable` high.
  - Stimulus: assert `rst` in the 3rd cycle of a read miss.
  - Required: `sram_read_enable`=0 and `ready`=1 immediately; the previously cached 0x400 misses afterwards.
